apb_master_bridge: RTL and testbench
====================================

APB_MASTER_BRIDGE -- requirements
Module: apb_master_bridge

Interface
REQ-001 Parameter DATA_WIDTH, default 32: APB and command data width in bits.
REQ-002 Parameter TIMEOUT_CYCLES, default 16: maximum ACCESS cycles before abort; used only when APB_MASTER_TIMEOUT_EN is defined.
REQ-003 PCLK  input  1  clock; all state updates on rising edge.
REQ-004 PRESET  input  1  asynchronous, active-high reset.
REQ-005 cmd_valid  input  1  command request.
REQ-006 cmd_ready  output  1  bridge accepts a command this cycle.
REQ-007 cmd_write  input  1  1 = write, 0 = read.
REQ-008 cmd_addr  input  32  byte address.
REQ-009 cmd_wdata  input  DATA_WIDTH  write data.
REQ-010 rsp_valid  output  1  response available.
REQ-011 rsp_ready  input  1  consumer accepts the response.
REQ-012 rsp_rdata  output  DATA_WIDTH  read data; 0 for writes.
REQ-013 rsp_err  output  1  transfer aborted.
REQ-014 last_wait  output  8  wait states of the last completed transfer.
REQ-015 PSEL, PENABLE, PWRITE  output  1 each  APB controls.
REQ-016 PADDR  output  32  APB byte address.
REQ-017 PWDATA  output  DATA_WIDTH  APB write data.
REQ-018 PRDATA  input  DATA_WIDTH  APB read data.
REQ-019 PREADY  input  1  APB completion.

Function
REQ-020 The FSM shall have the states IDLE, SETUP, ACCESS and RESP, and all outputs shall be driven from registers.
REQ-021 cmd_ready shall be 1 only in IDLE, and a command shall be accepted at an edge where cmd_valid && cmd_ready is true.
REQ-022 On acceptance: PADDR <= {cmd_addr[31:2],2'b00}; PWRITE <= cmd_write; PWDATA <= cmd_wdata (or 0 for reads); next state SETUP.
REQ-023 In SETUP, PSEL shall be 1 and PENABLE 0 for exactly one cycle, followed by ACCESS.
REQ-024 In ACCESS, PSEL and PENABLE shall be 1, and PADDR, PWRITE and PWDATA shall hold stable until completion.
REQ-025 At an ACCESS edge with PREADY=1, the bridge shall capture rsp_rdata <= PRDATA for reads or 0 for writes, set rsp_err <= 0, set PSEL and PENABLE <= 0, set rsp_valid <= 1, and go to RESP.
REQ-026 The wait-state counter shall increment on each ACCESS edge with PREADY=0 and saturate at 255; it shall be copied to last_wait on completion and cleared on entering SETUP.
REQ-027 In RESP, rsp_valid and the response data shall hold until rsp_ready=1, after which the state returns to IDLE and rsp_valid drops on the next cycle.
REQ-028 Minimum cadence shall be 4 cycles per transfer with zero wait states and rsp_ready tied to 1.
REQ-029 PREADY shall be ignored outside ACCESS, and cmd_valid shall be ignored outside IDLE.
REQ-030 PADDR, PWRITE and PWDATA shall retain their last values in IDLE and RESP.

Reset
REQ-031 While PRESET=1, regardless of state, the bridge shall force: state IDLE; PSEL, PENABLE, PWRITE, rsp_valid and rsp_err = 0; PADDR, PWDATA, rsp_rdata, last_wait and the wait counter = 0.
REQ-032 cmd_ready shall read 1 on the first cycle after reset release.
REQ-033 Reset asserted mid-transfer shall abandon the transfer with no response generated.

Configuration
REQ-034 With APB_MASTER_TIMEOUT_EN defined: when the wait counter reaches TIMEOUT_CYCLES in ACCESS without PREADY, the bridge shall drop PSEL and PENABLE, set rsp_rdata=0 and rsp_err=1, set last_wait=TIMEOUT_CYCLES, and enter RESP.
REQ-035 With APB_MASTER_TIMEOUT_EN defined, PREADY=1 arriving on the timeout edge itself shall win and produce a normal response.
REQ-036 Without APB_MASTER_TIMEOUT_EN, ACCESS shall wait indefinitely, rsp_err shall be constant 0, and no timeout logic shall be present.

Verification
REQ-037 Write, 2-wait slave: cmd write addr 0x0C, data 0xDEADBEEF -> PADDR=0x0C for 1 SETUP cycle plus 3 ACCESS cycles, rsp_err=0, last_wait=2.
REQ-038 Read, zero-wait slave returning 0xDEADBEEF at 0x0C -> exactly 1 ACCESS cycle, rsp_rdata=0xDEADBEEF, last_wait=0.
REQ-039 Unaligned address: cmd_addr=0x13 -> PADDR=0x10.
REQ-040 Backpressure: hold rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata stable, cmd_ready=0, PSEL=0 throughout.
REQ-041 Timeout, macro defined, PREADY stuck 0, TIMEOUT_CYCLES=16 -> abort after 16 ACCESS cycles, rsp_err=1, rsp_rdata=0.
REQ-042 Reset pulse during ACCESS -> PSEL=0, PENABLE=0 and rsp_valid=0 immediately, and no response after release.

Source files
------------

// File: rtl/apb_master_bridge.sv
// Command/response to APB master bridge: one outstanding transfer, with all outputs registered.
// Optional ACCESS-phase timeout abort is enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master_bridge #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [31:0]           cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [7:0]            last_wait,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [31:0]           PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must lie in 1..255");
  end

  typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

  state_e                state_q, state_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
  logic [31:0]           paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d, rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [7:0]            wait_cnt_q, wait_cnt_d, last_wait_q, last_wait_d;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam logic [8:0] TimeoutLim = 9'(TIMEOUT_CYCLES);
  logic rsp_err_q, rsp_err_d;
  logic timeout_hit;
  assign timeout_hit = ({1'b0, wait_cnt_q} + 9'd1) >= TimeoutLim;
  assign rsp_err     = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_valid_d = rsp_valid_q;
    wait_cnt_d  = wait_cnt_q;
    last_wait_d = last_wait_q;
`ifdef APB_MASTER_TIMEOUT_EN
    rsp_err_d   = rsp_err_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          paddr_d    = {cmd_addr[31:2], 2'b00};
          pwrite_d   = cmd_write;
          pwdata_d   = cmd_write ? cmd_wdata : '0;
          wait_cnt_d = 8'd0;
          psel_d     = 1'b1;
          state_d    = StSetup;
        end
      end
      StSetup: begin
        penable_d = 1'b1;
        state_d   = StAccess;
      end
      StAccess: begin
        if (PREADY) begin
          rsp_rdata_d = pwrite_q ? '0 : PRDATA;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          last_wait_d = wait_cnt_q;
`ifdef APB_MASTER_TIMEOUT_EN
          rsp_err_d   = 1'b0;
`endif
          state_d     = StResp;
        end else
`ifdef APB_MASTER_TIMEOUT_EN
        if (timeout_hit) begin
          rsp_rdata_d = '0;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          wait_cnt_d  = TimeoutLim[7:0];
          last_wait_d = TimeoutLim[7:0];
          state_d     = StResp;
        end else
`endif
        if (wait_cnt_q != 8'hFF) begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    // Registered so cmd_ready is high exactly while the FSM sits in IDLE.
    cmd_ready_d = (state_d == StIdle);
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q     <= StIdle;
      cmd_ready_q <= 1'b1;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_rdata_q <= '0;
      rsp_valid_q <= 1'b0;
      wait_cnt_q  <= 8'd0;
      last_wait_q <= 8'd0;
`ifdef APB_MASTER_TIMEOUT_EN
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_valid_q <= rsp_valid_d;
      wait_cnt_q  <= wait_cnt_d;
      last_wait_q <= last_wait_d;
`ifdef APB_MASTER_TIMEOUT_EN
      rsp_err_q   <= rsp_err_d;
`endif
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign last_wait = last_wait_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: transaction-level reference model checked every cycle,
// plus directed transfers with hand-computed expectations and a randomized soak.
module tb_apb_master_bridge;
  localparam int DW = 32;
  localparam int TO = 16;

  logic          PCLK = 1'b0;
  logic          PRESET = 1'b1;
  logic          cmd_valid = 1'b0, cmd_write = 1'b0, rsp_ready = 1'b0, PREADY = 1'b0;
  logic [31:0]   cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0, PRDATA = '0;
  logic          cmd_ready, rsp_valid, rsp_err, PSEL, PENABLE, PWRITE;
  logic [DW-1:0] rsp_rdata, PWDATA;
  logic [31:0]   PADDR;
  logic [7:0]    last_wait;

  apb_master_bridge #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .last_wait(last_wait), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY)
  );

  always #5 PCLK = ~PCLK;

  int n_tests = 0;
  int n_fail  = 0;
  logic chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: phase of the current transfer (0 idle, 1 setup, 2 access, 3 response)
  // plus the values each output must carry.
  int          m_phase;
  int          m_wait;
  logic [31:0] m_paddr;
  logic        m_pwrite, m_rvalid, m_err;
  logic [DW-1:0] m_pwdata, m_rdata;
  logic [7:0]  m_last;

  always @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      m_phase <= 0; m_wait <= 0; m_paddr <= '0; m_pwrite <= 1'b0; m_pwdata <= '0;
      m_rvalid <= 1'b0; m_err <= 1'b0; m_rdata <= '0; m_last <= 8'd0;
    end else begin
      case (m_phase)
        0: if (cmd_valid) begin
          m_paddr  <= cmd_addr & 32'hFFFF_FFFC;
          m_pwrite <= cmd_write;
          m_pwdata <= cmd_write ? cmd_wdata : '0;
          m_wait   <= 0;
          m_phase  <= 1;
        end
        1: m_phase <= 2;
        2: if (PREADY) begin
          m_rdata  <= m_pwrite ? '0 : PRDATA;
          m_err    <= 1'b0;
          m_rvalid <= 1'b1;
          m_last   <= 8'(m_wait);
          m_phase  <= 3;
        end else begin
`ifdef APB_MASTER_TIMEOUT_EN
          if (m_wait + 1 >= TO) begin
            m_rdata <= '0; m_err <= 1'b1; m_rvalid <= 1'b1;
            m_last <= 8'(TO); m_wait <= TO; m_phase <= 3;
          end else
`endif
          m_wait <= (m_wait < 255) ? m_wait + 1 : 255;
        end
        default: if (rsp_ready) begin
          m_rvalid <= 1'b0;
          m_phase  <= 0;
        end
      endcase
    end
  end

  initial forever begin
    @(negedge PCLK);
    if (chk_en) begin
      check("cmd_ready", cmd_ready, m_phase == 0);
      check("PSEL", PSEL, m_phase == 1 || m_phase == 2);
      check("PENABLE", PENABLE, m_phase == 2);
      check("PADDR", PADDR, m_paddr);
      check("PWRITE", PWRITE, m_pwrite);
      check("PWDATA", PWDATA, m_pwdata);
      check("rsp_valid", rsp_valid, m_rvalid);
      check("rsp_rdata", rsp_rdata, m_rdata);
      check("rsp_err", rsp_err, m_err);
      check("last_wait", last_wait, m_last);
    end
  end

  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  // One transfer driven by a slave that inserts nwait wait states, then bp cycles of
  // response backpressure. Returns what was observed on the bus and response.
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [DW-1:0] wdata,
                      input logic [DW-1:0] rdata, input int nwait, input int bp,
                      output int n_setup, output int n_acc, output logic [31:0] paddr_seen,
                      output logic [DW-1:0] pwdata_seen, output logic err_seen,
                      output logic [DW-1:0] rdata_seen, output logic [7:0] lw_seen);
    int guard;
    guard = 0;
    while (!cmd_ready && guard < 50) begin step(); guard++; end
    check("xfer_ready_bound", guard < 50, 1'b1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
    PRDATA = rdata; rsp_ready = 1'b0;
    step();
    cmd_valid = 1'b0;
    n_setup = 0; n_acc = 0; guard = 0; paddr_seen = '0; pwdata_seen = '0;
    while (!rsp_valid && guard < 100) begin
      if (PSEL && !PENABLE) n_setup++;
      if (PSEL && PENABLE) begin
        n_acc++;
        paddr_seen  = PADDR;
        pwdata_seen = PWDATA;
      end
      PREADY = PSEL && PENABLE && (n_acc == nwait + 1);
      step();
      guard++;
    end
    PREADY = 1'b0;
    check("xfer_rsp_bound", guard < 100, 1'b1);
    err_seen = rsp_err; rdata_seen = rsp_rdata; lw_seen = last_wait;
    for (int i = 0; i < bp; i++) begin
      cmd_valid = 1'b1;
      check("bp_rsp_valid", rsp_valid, 1'b1);
      check("bp_rsp_rdata", rsp_rdata, wr ? '0 : rdata);
      check("bp_cmd_ready", cmd_ready, 1'b0);
      check("bp_psel", PSEL, 1'b0);
      step();
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check("rsp_drop", rsp_valid, 1'b0);
  endtask

  int            ns, na, setups, resps;
  logic [31:0]   pa;
  logic [DW-1:0] pw, rd;
  logic          er;
  logic [7:0]    lw;

  initial begin
    step(); step();
    chk_en = 1'b1;
    PRESET = 1'b0;
    check("rst_cmd_ready", cmd_ready, 1'b1);
    check("rst_psel", PSEL, 1'b0);
    check("rst_paddr", PADDR, 32'h0);
    check("rst_last_wait", last_wait, 8'h0);
    check("rst_rsp_valid", rsp_valid, 1'b0);

    // Write to a 2-wait slave.
    xfer(1'b1, 32'h0C, 32'hDEADBEEF, 32'h0, 2, 0, ns, na, pa, pw, er, rd, lw);
    check("wr_setup_cycles", ns, 1);
    check("wr_access_cycles", na, 3);
    check("wr_paddr", pa, 32'h0C);
    check("wr_pwdata", pw, 32'hDEADBEEF);
    check("wr_err", er, 1'b0);
    check("wr_rdata", rd, 32'h0);
    check("wr_last_wait", lw, 8'd2);

    // Read from a zero-wait slave.
    xfer(1'b0, 32'h0C, 32'h1111_1111, 32'hDEADBEEF, 0, 0, ns, na, pa, pw, er, rd, lw);
    check("rd_access_cycles", na, 1);
    check("rd_rdata", rd, 32'hDEADBEEF);
    check("rd_pwdata_zero", pw, 32'h0);
    check("rd_last_wait", lw, 8'd0);

    // Unaligned read with 5 cycles of response backpressure.
    xfer(1'b0, 32'h13, 32'h0, 32'h1234_5678, 1, 5, ns, na, pa, pw, er, rd, lw);
    check("unal_paddr", pa, 32'h10);
    check("unal_rdata", rd, 32'h1234_5678);
    check("unal_last_wait", lw, 8'd1);

`ifdef APB_MASTER_TIMEOUT_EN
    xfer(1'b0, 32'h40, 32'h0, 32'hCAFE_F00D, 1000, 0, ns, na, pa, pw, er, rd, lw);
    check("to_access_cycles", na, TO);
    check("to_err", er, 1'b1);
    check("to_rdata", rd, 32'h0);
    check("to_last_wait", lw, 8'(TO));
    // Ready on the edge that would otherwise time out wins.
    xfer(1'b0, 32'h44, 32'h0, 32'hCAFE_F00D, TO - 1, 0, ns, na, pa, pw, er, rd, lw);
    check("to_race_err", er, 1'b0);
    check("to_race_rdata", rd, 32'hCAFE_F00D);
    check("to_race_last_wait", lw, 8'(TO - 1));
`endif

    // Back-to-back cadence: zero-wait slave, response always accepted.
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h20; PREADY = 1'b1; rsp_ready = 1'b1;
    setups = 0; resps = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (PSEL && !PENABLE) setups++;
      if (rsp_valid) resps++;
    end
    check("cadence_setups", setups, 3);
    check("cadence_resps", resps, 3);
    cmd_valid = 1'b0; PREADY = 1'b0; rsp_ready = 1'b0;
    while (!cmd_ready) step();

    // Reset pulse in the middle of ACCESS.
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h80; PRDATA = 32'hA5A5_A5A5;
    step();
    cmd_valid = 1'b0;
    step();
    check("mid_penable", PENABLE, 1'b1);
    #3 PRESET = 1'b1;
    PREADY = 1'b1; rsp_ready = 1'b1;
    #2;
    check("mid_rst_psel", PSEL, 1'b0);
    check("mid_rst_penable", PENABLE, 1'b0);
    check("mid_rst_rsp_valid", rsp_valid, 1'b0);
    step(); step();
    PRESET = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check("post_rst_rsp_valid", rsp_valid, 1'b0);
      check("post_rst_cmd_ready", cmd_ready, 1'b1);
      step();
    end
    PREADY = 1'b0; rsp_ready = 1'b0;

    // Randomized soak against the model.
    for (int i = 0; i < 600; i++) begin
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_write = 1'($urandom_range(0, 1));
      cmd_addr  = $urandom;
      cmd_wdata = $urandom;
      PRDATA    = $urandom;
      PREADY    = ($urandom_range(0, 2) == 0);
      rsp_ready = 1'($urandom_range(0, 1));
      step();
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
